// File: rtl/alu_pkg.sv
// Shared constants for the alu4 execute-stage ALU: opcode map and datapath widths.
package alu_pkg;

   localparam int DATA_W = 4;
   localparam int RES_W  = 5;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Combinational ALU core: next result and, with ALU_FLAGS_EN defined, next zero/ovf flags.
module alu4_core
   import alu_pkg::*;
(
   input  logic [2:0]        S,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
`ifdef ALU_FLAGS_EN
   output logic              nzero,
   output logic              novf,
`endif
   output logic [RES_W-1:0]  nres
);

   logic [RES_W-1:0] sum;
   logic [RES_W-1:0] dif;

   // 5-bit add/subtract so bit 4 is carry, or borrow (which also drives SLT)
   assign sum = {1'b0, A} + {1'b0, B};
   assign dif = {1'b0, A} - {1'b0, B};

   always_comb begin
      nres = '0;
      case (S)
         OP_ADD:  nres = sum;
         OP_SUB:  nres = dif;
         OP_AND:  nres = {1'b0, A & B};
         OP_OR:   nres = {1'b0, A | B};
         OP_XOR:  nres = {1'b0, A ^ B};
         OP_NOT:  nres = {1'b0, ~A};
         OP_SHL:  nres = {A, 1'b0};
         OP_SLT:  nres = {{(RES_W-1){1'b0}}, dif[DATA_W]};
         default: nres = '0;
      endcase
   end

`ifdef ALU_FLAGS_EN
   always_comb begin
      nzero = (nres == '0);
      novf  = 1'b0;
      if (S == OP_ADD)
         novf = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
      else if (S == OP_SUB)
         novf = (A[DATA_W-1] != B[DATA_W-1]) && (dif[DATA_W-1] != A[DATA_W-1]);
   end
`endif

endmodule

// File: rtl/alu4.sv
// Registered 4-bit, 8-op ALU. Macro ALU_FLAGS_EN adds registered zero/ovf flag ports.
module alu4
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        S,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
`ifdef ALU_FLAGS_EN
   output logic              zero,
   output logic              ovf,
`endif
   output logic [RES_W-1:0]  result
);

   logic [RES_W-1:0] nres;
`ifdef ALU_FLAGS_EN
   logic             nzero;
   logic             novf;
`endif

   alu4_core u_core (
      .S     (S),
      .A     (A),
      .B     (B),
`ifdef ALU_FLAGS_EN
      .nzero (nzero),
      .novf  (novf),
`endif
      .nres  (nres)
   );

   always_ff @(posedge clk) begin
      if (rst) result <= '0;
      else     result <= nres;
   end

`ifdef ALU_FLAGS_EN
   // Reset value matches the flags of a zero result
   always_ff @(posedge clk) begin
      if (rst) begin
         zero <= 1'b1;
         ovf  <= 1'b0;
      end else begin
         zero <= nzero;
         ovf  <= novf;
      end
   end
`endif

endmodule

// File: tb/tb_alu4.sv
// Self-checking bench for alu4: directed vector table, then random stimulus vs a reference model.
module tb_alu4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] S;
   logic [3:0] A;
   logic [3:0] B;
   logic [4:0] result;
`ifdef ALU_FLAGS_EN
   logic       zero;
   logic       ovf;
`endif

   int nvec = 0;
   int nerr = 0;

   alu4 dut (
      .clk    (clk),
      .rst    (rst),
      .S      (S),
      .A      (A),
      .B      (B),
`ifdef ALU_FLAGS_EN
      .zero   (zero),
      .ovf    (ovf),
`endif
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [2:0] s;
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] res;
      logic       z;
      logic       o;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [2:0] s, input logic [3:0] a,
                      input logic [3:0] b, input logic [4:0] res, input logic z,
                      input logic o);
      vec_t v;
      v.rst = r; v.s = s; v.a = a; v.b = b; v.res = res; v.z = z; v.o = o;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference model from the opcode rules, using plain integer arithmetic
   function automatic int model_res(input int s, input int a, input int b);
      case (s)
         0: return a + b;
         1: return (a - b + 32) % 32;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 15 - a;
         6: return (a * 2) % 32;
         default: return (a < b) ? 1 : 0;
      endcase
   endfunction

   function automatic int sgn(input int x);
      return (x >= 8) ? x - 16 : x;
   endfunction

   function automatic int model_ovf(input int s, input int a, input int b);
      int r;
      if (s == 0)      r = sgn(a) + sgn(b);
      else if (s == 1) r = sgn(a) - sgn(b);
      else return 0;
      return (r < -8 || r > 7) ? 1 : 0;
   endfunction

   task automatic step_check(input string name, input logic r, input logic [2:0] s,
                             input logic [3:0] a, input logic [3:0] b,
                             input int er, input int ez, input int eo);
      logic [4:0] held;
      rst = r; S = s; A = a; B = b;
      @(posedge clk);
      #1;
      chk({name, " result"}, result, er);
`ifdef ALU_FLAGS_EN
      chk({name, " zero"}, zero, ez);
      chk({name, " ovf"}, ovf, eo);
`else
      if (ez > 1 || eo > 1) $display("bad vector %s", name);
`endif
      // Inputs moving between edges must not disturb the registered output
      held = result;
      rst = 1'b0; S = 3'($urandom); A = 4'($urandom); B = 4'($urandom);
      @(negedge clk);
      chk({name, " hold"}, result, held);
   endtask

   initial begin
      int r, e;
      rst = 1'b1; S = '0; A = 4'd3; B = 4'd4;

      // Reset, release
      add(1, 0, 3, 4, 5'h00, 1, 0);
      add(1, 0, 3, 4, 5'h00, 1, 0);
      add(0, 0, 3, 4, 5'h07, 0, 0);
      // Opcode sweep A=3 B=4
      add(0, 0, 3, 4, 5'h07, 0, 0);
      add(0, 1, 3, 4, 5'h1F, 0, 0);
      add(0, 2, 3, 4, 5'h00, 1, 0);
      add(0, 3, 3, 4, 5'h07, 0, 0);
      add(0, 4, 3, 4, 5'h07, 0, 0);
      add(0, 5, 3, 4, 5'h0C, 0, 0);
      add(0, 6, 3, 4, 5'h06, 0, 0);
      add(0, 7, 3, 4, 5'h01, 0, 0);
      // Carry, SUB boundary, signed overflow
      add(0, 0, 15, 1, 5'h10, 0, 0);
      add(0, 1, 4, 4, 5'h00, 1, 0);
      add(0, 1, 0, 1, 5'h1F, 0, 0);
      add(0, 0, 7, 1, 5'h08, 0, 1);
      add(0, 1, 8, 1, 5'h07, 0, 1);
      add(0, 7, 4, 3, 5'h00, 1, 0);
      add(0, 6, 8, 0, 5'h10, 0, 0);
      // Mid-stream reset
      add(0, 0, 9, 9, 5'h12, 0, 1);
      add(1, 0, 9, 9, 5'h00, 1, 0);
      add(0, 0, 9, 9, 5'h12, 0, 1);

      @(negedge clk);
      foreach (tbl[i])
         step_check($sformatf("vec%0d", i), tbl[i].rst, tbl[i].s, tbl[i].a, tbl[i].b,
                    tbl[i].res, tbl[i].z, tbl[i].o);

      for (int i = 0; i < 400; i++) begin
         logic rr;
         logic [2:0] s;
         logic [3:0] a, b;
         rr = ($urandom_range(15) == 0);
         s = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
         r = rr ? 0 : model_res(s, a, b);
         e = rr ? 0 : model_ovf(s, a, b);
         step_check($sformatf("rnd%0d s%0d a%0d b%0d", i, s, a, b), rr, s, a, b,
                    r, (r == 0) ? 1 : 0, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu4.md
# alu4

4-bit, 8-operation registered ALU. Takes two 4-bit operands and a 3-bit opcode and produces a 5-bit result, where bit 4 carries the carry, borrow or extra result bit. It is a leaf datapath block for the lab processor's execute stage, with the output registered on the single system clock.

## Interface
- No parameters; widths are fixed (operand 4, result 5, opcode 3).
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- S  input  3  opcode selecting the operation.
- A  input  4  operand A, unsigned.
- B  input  4  operand B, unsigned.
- result  output  5  registered operation result.
- zero  output  1  registered flag, high when result == 0. Present only with ALU_FLAGS_EN.
- ovf  output  1  registered signed-overflow flag for ADD/SUB. Present only with ALU_FLAGS_EN.

## Operation
All operands are unsigned 4-bit unless stated. The opcode map is:
- 000 ADD: result = {carry, A+B}, i.e. a 5-bit sum.
- 001 SUB: result = {borrow, A-B mod 16}. borrow = 1 when A < B. Equivalent to the 5-bit two's-complement A-B.
- 010 AND: result = {0, A & B}.
- 011 OR: result = {0, A | B}.
- 100 XOR: result = {0, A ^ B}.
- 101 NOT: result = {0, ~A}; B is ignored.
- 110 SHL: result = {A, 0}, a logical left shift by 1; bit 4 receives A[3]. B is ignored.
- 111 SLT: result = 5'd1 if A < B, else 5'd0.

General rules:
- No illegal opcodes exist; all 8 codes are defined.
- Each operation is computed combinationally from the current S/A/B, then captured into the result register.
- Flags (when compiled in):
  - zero = (next result == 0) for every opcode.
  - ovf = signed 4-bit overflow for ADD/SUB: the operands' signs satisfy the overflow condition and the sign of the 4-bit result differs. For ADD the operand signs must be equal; for SUB they must differ.
  - ovf = 0 for all other opcodes.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on result (and the flags) after edge N and hold until edge N+1.
- There is no handshake. The register loads every cycle when rst is low; there is no enable.
- When rst is high at a rising edge, result = 0, zero = 1 and ovf = 0, regardless of S/A/B.
- If reset is deasserted in the middle of a stream, the first valid result is the one computed from the inputs sampled at the first edge with rst low.
- Input changes between edges have no effect on outputs until the next edge.
- Outputs are never combinational from the inputs.

## Configuration
- Macro ALU_FLAGS_EN.
- Defined: the zero and ovf ports and their registers exist, with the behaviour described above.
- Undefined: the ports and registers are absent. result behaviour is identical in both builds.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=3'b000 through OP_SLT=3'b111, in the order listed above;
  - width constants DATA_W=4 and RES_W=5.
- One sub-module, alu4_core: purely combinational, S/A/B in, next result (and next flags) out.
- The top module instantiates alu4_core and holds only the output registers and the reset logic.

## Test plan
1. Reset: hold rst=1 for 2 cycles with S=0, A=3, B=4 -> result=0 (zero=1, ovf=0 with flags). Release rst -> result=7 one cycle later.
2. Opcode sweep with A=3, B=4, S stepping 0..7, one step per cycle -> result = 7, 0x1F, 0, 7, 7, 0x0C, 6, 1, each appearing one cycle after its opcode.
3. ADD carry: A=15, B=1, S=0 -> result=0x10. With flags: zero=0, ovf=0.
4. SUB boundary: A=4, B=4, S=1 -> result=0, zero=1. A=0, B=1 -> result=0x1F.
5. Signed overflow (ALU_FLAGS_EN): ADD A=7, B=1 -> result=8, ovf=1. SUB A=8, B=1 -> result=7, ovf=1.
6. Mid-stream reset: run ADD A=9, B=9 (result 0x12) and assert rst for one cycle -> result=0 that cycle, then 0x12 resumes on the following cycle.
